// File: rtl/alu_issue_pkg.sv
// ALU issue unit shared definitions: ALU op encoding, func codes
// and the func -> ALU op decode helper.
package alu_issue_pkg;

  localparam logic [3:0] ALU_SUB  = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_NAND = 4'b1100;
  localparam logic [3:0] ALU_NOR  = 4'b1101;
  localparam logic [3:0] ALU_NXOR = 4'b1110;

  localparam logic [3:0] FUNC_ADD  = 4'd0;
  localparam logic [3:0] FUNC_SUB  = 4'd1;
  localparam logic [3:0] FUNC_AND  = 4'd4;
  localparam logic [3:0] FUNC_OR   = 4'd5;
  localparam logic [3:0] FUNC_XOR  = 4'd6;
  localparam logic [3:0] FUNC_NAND = 4'd8;
  localparam logic [3:0] FUNC_NOR  = 4'd9;
  localparam logic [3:0] FUNC_NXOR = 4'd10;
  localparam logic [3:0] FUNC_MVHI = 4'd15;

  typedef struct packed {
    logic [3:0] op;
    logic       is_mvhi;
    logic       illegal;
  } dec_t;

  function automatic dec_t decode_func(
    input logic [3:0] func
  );
    dec_t d;
    d.op      = ALU_ADD;
    d.is_mvhi = 1'b0;
    d.illegal = 1'b0;
    case (func)
      FUNC_ADD:  d.op = ALU_ADD;
      FUNC_SUB:  d.op = ALU_SUB;
      FUNC_AND:  d.op = ALU_AND;
      FUNC_OR:   d.op = ALU_OR;
      FUNC_XOR:  d.op = ALU_XOR;
      FUNC_NAND: d.op = ALU_NAND;
      FUNC_NOR:  d.op = ALU_NOR;
      FUNC_NXOR: d.op = ALU_NXOR;
      FUNC_MVHI: begin
        d.op      = ALU_ADD;
        d.is_mvhi = 1'b1;
      end
      default:   d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational func/operand mapping feeding the ISSUE register.
// Illegal-func trapping is enabled by ALU_ISSUE_ILLEGAL_TRAP_EN.
module alu_issue_decode
  import alu_issue_pkg::*;
#(
  parameter int DBITS     = 32,
  parameter int FUNC_BITS = 4
) (
  input  logic [FUNC_BITS-1:0] func,
  input  logic [DBITS-1:0]     opA,
  input  logic [DBITS-1:0]     opB,
  output logic [3:0]           op,
  output logic [DBITS-1:0]     a,
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  output logic                 err,
`endif
  output logic [DBITS-1:0]     b
);

  localparam int H = DBITS / 2;

  dec_t dec;

  // map func to ALU op; MVHI becomes 0 + (imm << DBITS/2)
  always_comb begin
    dec = decode_func(func);
    op  = dec.op;
    a   = opA;
    b   = opB;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    err = 1'b0;
`endif
    unique case (1'b1)
      dec.illegal: begin
        op = ALU_ADD;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        a   = '0;
        b   = '0;
        err = 1'b1;
`endif
      end
      dec.is_mvhi: begin
        a = '0;
        b = {opB[H-1:0], {H{1'b0}}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue_unit.sv
// ALU issue front end: ISSUE reg -> external ALU -> RESULT reg,
// valid/ready on both sides. Optional ALU_ISSUE_ILLEGAL_TRAP_EN.
module alu_issue_unit
  import alu_issue_pkg::*;
#(
  parameter int DBITS            = 32,
  parameter int OPCODE_BIT_WIDTH = 4,
  parameter int FUNC_BITS        = 4,
  parameter int TAG_BITS         = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [FUNC_BITS-1:0]        in_func,
  input  logic [DBITS-1:0]            in_opA,
  input  logic [DBITS-1:0]            in_opB,
  input  logic [TAG_BITS-1:0]         in_tag,
  output logic [OPCODE_BIT_WIDTH-1:0] aluOp,
  output logic [DBITS-1:0]            inA,
  output logic [DBITS-1:0]            inB,
  input  logic [DBITS-1:0]            outAlu,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DBITS-1:0]            out_result,
  output logic [TAG_BITS-1:0]         out_tag,
  output logic                        out_err
);

  logic                iss_v;
  logic                res_v;
  logic [TAG_BITS-1:0] iss_tag;
  logic [3:0]          dec_op;
  logic [DBITS-1:0]    dec_a;
  logic [DBITS-1:0]    dec_b;
  logic                accept;
  logic                res_load;

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  logic dec_err;
  logic iss_err;
`endif

  alu_issue_decode #(
    .DBITS     (DBITS),
    .FUNC_BITS (FUNC_BITS)
  ) u_dec (
    .func (in_func),
    .opA  (in_opA),
    .opB  (in_opB),
    .op   (dec_op),
    .a    (dec_a),
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    .err  (dec_err),
`endif
    .b    (dec_b)
  );

  // RESULT drains or is empty -> ISSUE can always move forward
  assign in_ready  = !iss_v || !res_v || out_ready;
  assign accept    = in_valid && in_ready;
  assign res_load  = iss_v && (!res_v || out_ready);
  assign out_valid = res_v;

  // ISSUE stage: operands held stable until the next accept
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      iss_v   <= 1'b0;
      aluOp   <= '0;
      inA     <= '0;
      inB     <= '0;
      iss_tag <= '0;
    end else begin
      iss_v <= accept || (iss_v && !res_load);
      if (accept) begin
        aluOp   <= dec_op;
        inA     <= dec_a;
        inB     <= dec_b;
        iss_tag <= in_tag;
      end
    end
  end

  // RESULT stage: capture the ALU output, hold while stalled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_v      <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
    end else begin
      res_v <= res_load || (res_v && !out_ready);
      if (res_load) begin
        out_result <= outAlu;
        out_tag    <= iss_tag;
      end
    end
  end

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  // error flag travels with its op through both stages
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      iss_err <= 1'b0;
      out_err <= 1'b0;
    end else begin
      if (accept)   iss_err <= dec_err;
      if (res_load) out_err <= iss_err;
    end
  end
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a behavioural ALU model.
// Honours ALU_ISSUE_ILLEGAL_TRAP_EN for the illegal-func case.
module tb_alu_issue_unit;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_func;
  logic [31:0] in_opA;
  logic [31:0] in_opB;
  logic [3:0]  in_tag;
  logic [3:0]  aluOp;
  logic [31:0] inA;
  logic [31:0] inB;
  logic [31:0] outAlu;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_tag;
  logic        out_err;

  int tests = 0;
  int fails = 0;

  alu_issue_unit dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_func    (in_func),
    .in_opA     (in_opA),
    .in_opB     (in_opB),
    .in_tag     (in_tag),
    .aluOp      (aluOp),
    .inA        (inA),
    .inB        (inB),
    .outAlu     (outAlu),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_err    (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // combinational ALU
  always_comb begin
    outAlu = 32'h0;
    case (aluOp)
      4'b0000: outAlu = inA - inB;
      4'b0001: outAlu = inA + inB;
      4'b0100: outAlu = inA & inB;
      4'b0101: outAlu = inA | inB;
      4'b0110: outAlu = inA ^ inB;
      4'b1100: outAlu = ~(inA & inB);
      4'b1101: outAlu = ~(inA | inB);
      4'b1110: outAlu = ~(inA ^ inB);
      default: outAlu = 32'h0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // one op through an idle pipe with out_ready high
  task automatic do_op(input string nm, input logic [3:0] f,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] t, input logic [3:0] e_op,
                       input logic [31:0] e_a, input logic [31:0] e_b,
                       input logic [31:0] e_res, input logic e_err);
    int n;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_func   = f;
    in_opA    = a;
    in_opB    = b;
    in_tag    = t;
    #1;
    chk({nm, ".in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({nm, ".aluOp"}, 32'(aluOp), 32'(e_op));
    chk({nm, ".inA"}, inA, e_a);
    chk({nm, ".inB"}, inB, e_b);
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, ".latency"}, 32'(n), 32'd1);
    chk({nm, ".result"}, out_result, e_res);
    chk({nm, ".tag"}, 32'(out_tag), 32'(t));
    chk({nm, ".err"}, 32'(out_err), 32'(e_err));
    @(posedge clk); #1;
    chk({nm, ".drained"}, 32'(out_valid), 32'd0);
  endtask

  logic [31:0] exp_res [4];
  logic [3:0]  exp_tag [4];
  logic [3:0]  q_func  [4];
  logic [31:0] q_a     [4];
  logic [31:0] q_b     [4];
  logic [31:0] got_res [$];
  logic [3:0]  got_tag [$];

  initial begin
    int i;
    int stall;
    int cyc;
    logic first_seen;
    logic saw_block;
    logic acc;
    logic [31:0] held;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_func   = 4'd0;
    in_opA    = 32'h0;
    in_opB    = 32'h0;
    in_tag    = 4'd0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.aluOp", 32'(aluOp), 32'd0);
    chk("rst.inA", inA, 32'd0);
    chk("rst.inB", inB, 32'd0);
    chk("rst.result", out_result, 32'd0);
    chk("rst.tag", 32'(out_tag), 32'd0);
    chk("rst.err", 32'(out_err), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst.in_ready", 32'(in_ready), 32'd1);

    do_op("add", 4'd0, 32'd5, 32'd3, 4'd2,
          4'b0001, 32'd5, 32'd3, 32'd8, 1'b0);
    do_op("sub", 4'd1, 32'd3, 32'd5, 4'd3,
          4'b0000, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0);
    do_op("nand", 4'd8, 32'hF0F0, 32'hFF00, 4'd4,
          4'b1100, 32'hF0F0, 32'hFF00, 32'hFFFF_0FFF, 1'b0);
    do_op("mvhi", 4'd15, 32'hDEAD_BEEF, 32'h0000_1234, 4'd5,
          4'b0001, 32'h0, 32'h1234_0000, 32'h1234_0000, 1'b0);
    do_op("and", 4'd4, 32'hFF00_FF00, 32'h0F0F_0F0F, 4'd6,
          4'b0100, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1'b0);
    do_op("or", 4'd5, 32'h00F0, 32'h0F00, 4'd7,
          4'b0101, 32'h00F0, 32'h0F00, 32'h0FF0, 1'b0);
    do_op("xor", 4'd6, 32'hFF00_FF00, 32'h0F0F_0F0F, 4'd8,
          4'b0110, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F, 1'b0);
    do_op("nor", 4'd9, 32'hF0F0_F0F0, 32'h0F0F_0000, 4'd9,
          4'b1101, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0000_0F0F, 1'b0);
    do_op("nxor", 4'd10, 32'hAAAA_5555, 32'hFFFF_0000, 4'd10,
          4'b1110, 32'hAAAA_5555, 32'hFFFF_0000, 32'hAAAA_AAAA, 1'b0);
    do_op("wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 4'd11,
          4'b0001, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    do_op("illegal", 4'd3, 32'd7, 32'd9, 4'd12,
          4'b0001, 32'd0, 32'd0, 32'd0, 1'b1);
`else
    do_op("illegal", 4'd3, 32'd7, 32'd9, 4'd12,
          4'b0001, 32'd7, 32'd9, 32'd16, 1'b0);
`endif

    // back-to-back stream with a 3-cycle downstream stall
    q_func[0] = 4'd0; q_a[0] = 32'd1;  q_b[0] = 32'd1;
    q_func[1] = 4'd1; q_a[1] = 32'd10; q_b[1] = 32'd3;
    q_func[2] = 4'd6; q_a[2] = 32'hF;  q_b[2] = 32'h5;
    q_func[3] = 4'd5; q_a[3] = 32'h8;  q_b[3] = 32'h1;
    exp_res[0] = 32'd2;
    exp_res[1] = 32'd7;
    exp_res[2] = 32'hA;
    exp_res[3] = 32'h9;
    for (int k = 0; k < 4; k++) exp_tag[k] = 4'(k + 1);
    i = 0;
    stall = 0;
    cyc = 0;
    first_seen = 1'b0;
    saw_block = 1'b0;
    held = 32'h0;
    while (got_res.size() < 4 && cyc < 40) begin
      if (i < 4) begin
        in_valid = 1'b1;
        in_func  = q_func[i];
        in_opA   = q_a[i];
        in_opB   = q_b[i];
        in_tag   = exp_tag[i];
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid && !first_seen) begin
        first_seen = 1'b1;
        stall = 3;
        held = out_result;
      end
      if (stall > 0 && stall < 3)
        chk("b2b.stall_hold", out_result, held);
      out_ready = (stall == 0);
      if (stall > 0) stall--;
      #1;
      if (!in_ready) saw_block = 1'b1;
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        got_res.push_back(out_result);
        got_tag.push_back(out_tag);
      end
      @(posedge clk); #1;
      if (acc) i++;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("b2b.count", 32'(got_res.size()), 32'd4);
    chk("b2b.blocked", 32'(saw_block), 32'd1);
    for (int k = 0; k < 4; k++) begin
      if (k < got_res.size()) begin
        chk($sformatf("b2b.res%0d", k), got_res[k], exp_res[k]);
        chk($sformatf("b2b.tag%0d", k), 32'(got_tag[k]),
            32'(exp_tag[k]));
      end
    end
    repeat (3) @(posedge clk);
    #1;
    chk("b2b.no_dup", 32'(out_valid), 32'd0);

    // fill both stages, stall, then reset mid-stall
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_func   = 4'd0;
    in_opA    = 32'd100;
    in_opB    = 32'd1;
    in_tag    = 4'd13;
    @(posedge clk); #1;
    in_opA = 32'd200;
    in_tag = 4'd14;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("full.out_valid", 32'(out_valid), 32'd1);
    chk("full.in_ready", 32'(in_ready), 32'd0);
    chk("full.result", out_result, 32'd101);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mrst.out_valid", 32'(out_valid), 32'd0);
    chk("mrst.result", out_result, 32'd0);
    chk("mrst.tag", 32'(out_tag), 32'd0);
    chk("mrst.aluOp", 32'(aluOp), 32'd0);
    chk("mrst.inA", inA, 32'd0);
    chk("mrst.inB", inB, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("mrst.in_ready", 32'(in_ready), 32'd1);
    chk("mrst.empty", 32'(out_valid), 32'd0);
    do_op("post", 4'd0, 32'd2, 32'd2, 4'd5,
          4'b0001, 32'd2, 32'd2, 32'd4, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
